// File: rtl/priority_decoder_dispatch.sv
// Priority-decoder dispatch: latches an encoded index and holds the
// matching one-hot line until the consumer acks or the hold times out.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   in_valid      encoded index present
//   in_idx        encoded index (IDX_W bits)
//   in_ready      high while idle (combinational)
//   out_onehot    registered one-hot line, zero when idle
//   out_valid     a line is being driven
//   out_ack       consumer of the active line accepts
//   timeout_err   one-cycle pulse when a hold expires without ack
//   event_cnt     acked dispatches, saturating at 255
module priority_decoder_dispatch #(
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  in_ready,
  output logic [2**IDX_W-1:0]   out_onehot,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  timeout_err,
  output logic [7:0]            event_cnt
);

  localparam int N = 2**IDX_W;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold;
  logic [N-1:0]     dec;

  // full binary-to-one-hot decode; every index value is legal
  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) begin
      dec[i] = (in_idx == IDX_W'(i));
    end
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      out_onehot  <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      event_cnt   <= 8'd0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            out_onehot <= dec;
            out_valid  <= 1'b1;
            hold       <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          // ack has priority over an expiring hold
          if (out_ack) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
            if (event_cnt != 8'hff) begin
              event_cnt <= event_cnt + 8'd1;
            end
          end else if (hold == HOLD_LAST) begin
            out_onehot  <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            hold <= hold + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_decoder_dispatch.sv
// Bench for priority_decoder_dispatch: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_priority_decoder_dispatch;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_idx;
  logic       in_ready;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic       out_ack;
  logic       timeout_err;
  logic [7:0] event_cnt;

  int total = 0;
  int bad   = 0;
  bit en    = 0;

  priority_decoder_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_idx      (in_idx),
    .in_ready    (in_ready),
    .out_onehot  (out_onehot),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .timeout_err (timeout_err),
    .event_cnt   (event_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // model: a pending dispatch is (line, cycles held so far)
  bit m_busy;
  int m_line;
  int m_held;
  int m_cnt;
  bit m_terr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_line = 0;
      m_held = 0;
      m_cnt  = 0;
      m_terr = 0;
    end else begin
      m_terr = 0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1;
          m_line = int'(in_idx);
          m_held = 1;
        end
      end else if (out_ack) begin
        m_busy = 0;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (m_held >= TO) begin
        m_busy = 0;
        m_terr = 1;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("onehot", int'(out_onehot), m_busy ? (2 ** m_line) : 0);
      chk("valid", int'(out_valid), int'(m_busy));
      chk("ready", int'(in_ready), int'(!m_busy));
      chk("terr", int'(timeout_err), int'(m_terr));
      chk("cnt", int'(event_cnt), m_cnt);
    end
  end

  task automatic idle_in();
    in_valid = 0;
    in_idx   = 0;
    out_ack  = 0;
  endtask

  int vcnt;
  int tcnt;
  int c0;

  initial begin
    rst_n = 0;
    idle_in();
    repeat (3) @(negedge clk);
    rst_n = 1;
    en = 1;

    // decode sweep, ack two cycles after accept
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_idx   = 2'(i);
      @(negedge clk);
      in_valid = 0;
      chk("sweep_oh", int'(out_onehot), 1 << i);
      @(negedge clk);
      out_ack = 1;
      @(negedge clk);
      out_ack = 0;
      chk("sweep_clr", int'(out_valid), 0);
    end
    chk("sweep_cnt", int'(event_cnt), 4);

    // timeout with no ack
    @(negedge clk);
    in_valid = 1;
    in_idx   = 2'd1;
    @(negedge clk);
    in_valid = 0;
    vcnt = 0;
    tcnt = 0;
    for (int i = 0; i < 22; i++) begin
      if (out_valid) vcnt++;
      if (timeout_err) tcnt++;
      @(negedge clk);
    end
    chk("to_hold", vcnt, 15);
    chk("to_pulse", tcnt, 1);
    chk("to_cnt", int'(event_cnt), 4);

    // ack on the last hold cycle
    in_valid = 1;
    in_idx   = 2'd2;
    @(negedge clk);
    in_valid = 0;
    repeat (14) @(negedge clk);
    chk("last_held", int'(out_valid), 1);
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
    chk("last_terr", int'(timeout_err), 0);
    chk("last_cnt", int'(event_cnt), 5);
    @(negedge clk);
    chk("last_terr2", int'(timeout_err), 0);

    // back-pressure: new index offered while driving
    in_valid = 1;
    in_idx   = 2'd3;
    @(negedge clk);
    in_idx = 2'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_oh", int'(out_onehot), 8);
      @(negedge clk);
    end
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
    chk("bp_idle", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_next", int'(out_onehot), 1);
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_idx   = 2'($urandom);
      out_ack  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    idle_in();
    repeat (20) @(negedge clk);

    // reset in the middle of a hold on line 2
    in_valid = 1;
    in_idx   = 2'd2;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("rst_pre", int'(out_onehot), 4);
    c0 = int'(event_cnt);
    #2;
    rst_n = 0;
    #1;
    chk("rst_oh", int'(out_onehot), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_cnt", int'(event_cnt), 0);
    @(negedge clk);
    rst_n = 1;

    // saturation after 260 acked dispatches
    for (int i = 0; i < 260; i++) begin
      in_valid = 1;
      in_idx   = 2'($urandom);
      @(negedge clk);
      in_valid = 0;
      out_ack  = 1;
      @(negedge clk);
      out_ack = 0;
      if (i == 254) chk("sat_255", int'(event_cnt), 255);
    end
    chk("sat_cnt", int'(event_cnt), 255);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
